// File: rtl/robot_ctrl_pkg.sv
// Shared types for the motor sequencer: sequencer state encoding and command codes.
// The decode helpers keep the command priority (brake beats drive) in one place.
package robot_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_BRAKE = 2'b10,
        ST_DEAD  = 2'b11
    } motor_state_e;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_DRIVE = 2'b01;
    localparam logic [1:0] CMD_BRAKE = 2'b10;

    function automatic logic [1:0] decode_cmd(input logic drive, input logic brake);
        logic [1:0] cmd;
        if (brake)
            cmd = CMD_BRAKE;
        else if (drive)
            cmd = CMD_DRIVE;
        else
            cmd = CMD_NONE;
        return cmd;
    endfunction

    function automatic motor_state_e cmd_target(input logic [1:0] cmd);
        motor_state_e st;
        case (cmd)
            CMD_DRIVE: st = ST_DRIVE;
            CMD_BRAKE: st = ST_BRAKE;
            default:   st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/motor_dwell_counter.sv
// Saturating 8-bit dwell counter; clear wins over enable.
module motor_dwell_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= 8'd0;
        else if (enable && (count != 8'hFF))
            count <= count + 8'd1;
    end

endmodule

// File: rtl/robot_motor_sequencer.sv
// Motor drive/brake sequencer with dead-time, minimum on-time, estop and
// manual/auto ownership arbitration. Outputs are Moore-decoded and registered.
//
// state | meaning
// IDLE  | motor off, waiting for a command
// DRIVE | forward enable asserted
// BRAKE | brake enable asserted
// DEAD  | both outputs low between changeovers
module robot_motor_sequencer #(
    parameter int DEAD_CYCLES   = 4,
    parameter int MIN_ON_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       auto_drive,
    input  logic       auto_brake,
    input  logic       man_req,
    input  logic       man_drive,
    input  logic       man_brake,
    input  logic       estop,
    output logic       motor_fwd,
    output logic       motor_brk,
    output logic       man_gnt,
    output logic [1:0] state_o
);
    import robot_ctrl_pkg::*;

    localparam logic [7:0] DEAD_LAST   = 8'(DEAD_CYCLES - 1);
    localparam logic [7:0] MIN_ON_LAST = 8'(MIN_ON_CYCLES - 1);

    motor_state_e state;
    motor_state_e state_next;
    logic [7:0]   dwell;
    logic [1:0]   cmd;
    logic         last_dead;
    logic         eval_owner;
    logic         owner;
    logic         min_on_done;
    logic         dwell_clear;
    logic         dwell_enable;

    // Ownership is re-decided only in IDLE or on the final DEAD cycle, and the
    // command that cycle already follows the new owner.
    always_comb begin
        last_dead   = (state == ST_DEAD) && (dwell == DEAD_LAST);
        eval_owner  = (state == ST_IDLE) || last_dead;
        owner       = eval_owner ? man_req : man_gnt;
        min_on_done = (dwell >= MIN_ON_LAST);
        if (owner)
            cmd = man_req ? decode_cmd(man_drive, man_brake) : CMD_NONE;
        else
            cmd = decode_cmd(auto_drive, auto_brake);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (estop)
                    state_next = ST_BRAKE;
                else
                    state_next = cmd_target(cmd);
            end
            ST_DRIVE: begin
                if (estop || ((cmd != CMD_DRIVE) && min_on_done))
                    state_next = ST_DEAD;
            end
            ST_BRAKE: begin
                if (!estop && (cmd != CMD_BRAKE) && min_on_done)
                    state_next = ST_DEAD;
            end
            ST_DEAD: begin
                if (last_dead)
                    state_next = estop ? ST_BRAKE : cmd_target(cmd);
            end
        endcase
    end

    assign dwell_clear  = (state_next != state);
    assign dwell_enable = (state_next != ST_IDLE);

    motor_dwell_counter u_dwell (
        .clk    (clk),
        .reset  (reset),
        .clear  (dwell_clear),
        .enable (dwell_enable),
        .count  (dwell)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            man_gnt   <= 1'b0;
            motor_fwd <= 1'b0;
            motor_brk <= 1'b0;
        end else begin
            state     <= state_next;
            if (eval_owner)
                man_gnt <= man_req;
            motor_fwd <= (state_next == ST_DRIVE);
            motor_brk <= (state_next == ST_BRAKE);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_robot_motor_sequencer.sv
// Bench for robot_motor_sequencer: phase/time model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_robot_motor_sequencer;

    localparam int DEAD_CYCLES   = 4;
    localparam int MIN_ON_CYCLES = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       auto_drive, auto_brake, man_req, man_drive, man_brake, estop;
    logic       motor_fwd, motor_brk, man_gnt;
    logic [1:0] state_o;

    int tests = 0;
    int fails = 0;

    robot_motor_sequencer #(
        .DEAD_CYCLES   (DEAD_CYCLES),
        .MIN_ON_CYCLES (MIN_ON_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .auto_drive (auto_drive),
        .auto_brake (auto_brake),
        .man_req    (man_req),
        .man_drive  (man_drive),
        .man_brake  (man_brake),
        .estop      (estop),
        .motor_fwd  (motor_fwd),
        .motor_brk  (motor_brk),
        .man_gnt    (man_gnt),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 drive, 2 brake, 3 dead; m_time = edges spent in
    // the phase since entry; dead_left counts the remaining dead cycles.
    int m_phase = 0;
    int m_time = 0;
    int dead_left = 0;
    bit m_gnt = 1'b0;
    bit m_valid = 1'b0;

    function automatic int want(input bit d, input bit b);
        if (b) return 2;
        if (d) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int  c;
        int  nxt;
        bit  own;
        bit  decide;
        if (reset) begin
            m_phase = 0;
            m_time  = 0;
            m_gnt   = 1'b0;
            m_valid = 1'b1;
        end else begin
            decide = (m_phase == 0) || (m_phase == 3 && dead_left == 1);
            own    = decide ? man_req : m_gnt;
            if (own) c = man_req ? want(man_drive, man_brake) : 0;
            else     c = want(auto_drive, auto_brake);
            nxt = m_phase;
            if (m_phase == 0)
                nxt = estop ? 2 : c;
            else if (m_phase == 1)
                nxt = (estop || (c != 1 && m_time + 1 >= MIN_ON_CYCLES)) ? 3 : 1;
            else if (m_phase == 2)
                nxt = (!estop && c != 2 && m_time + 1 >= MIN_ON_CYCLES) ? 3 : 2;
            else if (dead_left == 1)
                nxt = estop ? 2 : c;
            if (decide) m_gnt = man_req;
            if (m_phase == 3) dead_left = dead_left - 1;
            if (nxt == 3 && m_phase != 3) dead_left = DEAD_CYCLES;
            m_time  = (nxt != m_phase) ? 0 : m_time + 1;
            m_phase = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if (motor_fwd !== (m_phase == 1) || motor_brk !== (m_phase == 2) ||
                man_gnt !== m_gnt || state_o !== 2'(m_phase)) begin
                fails++;
                $display("FAIL model_cmp t=%0t: got fwd=%0b brk=%0b gnt=%0b st=%0d, want fwd=%0b brk=%0b gnt=%0b st=%0d",
                         $time, motor_fwd, motor_brk, man_gnt, state_o,
                         (m_phase == 1), (m_phase == 2), m_gnt, m_phase);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic ad, input logic ab, input logic mr,
                          input logic md, input logic mb, input logic es);
        auto_drive = ad;
        auto_brake = ab;
        man_req    = mr;
        man_drive  = md;
        man_brake  = mb;
        estop      = es;
    endtask

    task automatic chk(input string name, input int k, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d, want %0d", name, k, act, exp);
        end
    endtask

    // Literal expectation on the DUT outputs, also pinned against the model.
    task automatic lit(input string name, input int k, input bit fwd, input bit brk);
        chk({name, "_fwd"}, k, int'(motor_fwd), int'(fwd));
        chk({name, "_brk"}, k, int'(motor_brk), int'(brk));
        chk({name, "_model"}, k, m_phase == 1 ? 1 : (m_phase == 2 ? 2 : 0),
            fwd ? 1 : (brk ? 2 : 0));
    endtask

    task automatic reset_seq();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_in(1, 1, 1, 1, 1, 1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_fwd", k, int'(motor_fwd), 0);
            chk("rst_brk", k, int'(motor_brk), 0);
            chk("rst_gnt", k, int'(man_gnt), 0);
            chk("rst_state", k, int'(state_o), 0);
        end

        // Drive then brake request: full min-on, then dead time
        reset_seq();
        for (int k = 0; k < 14; k++) begin
            if (k < 2) set_in(1, 0, 0, 0, 0, 0);
            else       set_in(0, 1, 0, 0, 0, 0);
            step();
            lit("drv_brk", k, k <= 7, k >= 12);
        end

        // Estop during drive
        reset_seq();
        for (int k = 0; k < 10; k++) begin
            set_in(1, 0, 0, 0, 0, k >= 3);
            step();
            lit("estop", k, k < 3, k >= 7);
            if (k >= 3 && k <= 6) chk("estop_dead", k, int'(state_o), 3);
        end
        for (int k = 10; k < 30; k++) begin
            set_in(1, 0, 0, 0, 0, 0);
            step();
        end

        // Drive and brake together decode as brake
        reset_seq();
        for (int k = 0; k < 6; k++) begin
            set_in(1, 1, 0, 0, 0, 0);
            step();
            lit("both", k, 0, 1);
        end

        // Manual takes over only after auto releases and dead time ends
        reset_seq();
        for (int k = 0; k < 14; k++) begin
            set_in(0, k < 3, k >= 1, k >= 1, 0, 0);
            step();
            chk("man_gnt", k, int'(man_gnt), int'(k >= 12));
            if (k >= 8 && k <= 11) chk("man_dead", k, int'(state_o), 3);
            if (k >= 12) lit("man_drv", k, 1, 0);
        end
        for (int k = 14; k < 25; k++) begin
            set_in(0, 0, 0, 1, 0, 0);
            step();
            if (k == 23) chk("man_hold", k, int'(man_gnt), 1);
            if (k == 24) begin
                chk("man_rel_gnt", k, int'(man_gnt), 0);
                chk("man_rel_state", k, int'(state_o), 0);
            end
        end

        // Reset mid-drive, then a fresh drive gets its full dwell
        reset_seq();
        for (int k = 0; k < 18; k++) begin
            reset = (k == 4);
            set_in(k <= 5, 0, 0, 0, 0, 0);
            step();
            if (k == 4) begin
                lit("rst_mid", k, 0, 0);
                chk("rst_mid_state", k, int'(state_o), 0);
                chk("rst_mid_gnt", k, int'(man_gnt), 0);
            end
            if (k >= 5 && k <= 12) lit("redrive", k, 1, 0);
            if (k >= 13 && k <= 16) chk("redrive_dead", k, int'(state_o), 3);
            if (k == 17) chk("redrive_idle", k, int'(state_o), 0);
        end
        reset = 1'b0;

        // Mixed traffic checked by the model
        for (int k = 0; k < 300; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_in(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0) | man_req & 1'($urandom_range(0, 7) != 0),
                   1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 19) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/robot_motor_sequencer.md
ROBOT_MOTOR_SEQUENCER -- requirements
Module: robot_motor_sequencer

Interface
REQ-001 Parameter: DEAD_CYCLES, default 4, number of cycles both motor outputs are held low between any drive/brake changeover (legal range 1..255).
REQ-002 Parameter: MIN_ON_CYCLES, default 8, minimum cycles a DRIVE or BRAKE phase lasts before a normal command change is honoured (legal range 1..255).
REQ-003 Port list (name direction width meaning):
 clk  in  1  single clock, all state updates on rising edge
 reset  in  1  synchronous, active-high reset
 auto_drive  in  1  drive request from the sensor FSM (its Z1)
 auto_brake  in  1  brake request from the sensor FSM (its Z2)
 man_req  in  1  manual/remote requester wants ownership
 man_drive  in  1  manual drive command
 man_brake  in  1  manual brake command
 estop  in  1  emergency stop, level-sensitive
 motor_fwd  out  1  forward motor enable, registered
 motor_brk  out  1  brake enable, registered
 man_gnt  out  1  1 = manual requester owns the motor, registered
 state_o  out  2  current sequencer state encoding

Function
REQ-004 Effective command SHALL come from the owner: manual pair when man_gnt=1, auto pair otherwise; owner with man_gnt=1 and man_req=0 SHALL present command NONE.
REQ-005 Command decode SHALL be: drive only -> DRIVE_CMD; brake set (with or without drive) -> BRAKE_CMD; neither -> NONE.
REQ-006 States SHALL be IDLE=00, DRIVE=01, BRAKE=10, DEAD=11; outputs Moore-decoded and registered: IDLE 00, DRIVE fwd=1, BRAKE brk=1, DEAD 00 (fwd,brk never both 1).
REQ-007 IDLE: DRIVE_CMD -> DRIVE; BRAKE_CMD -> BRAKE; NONE -> stay; estop=1 -> BRAKE (overrides command).
REQ-008 DRIVE: command != DRIVE_CMD and dwell count >= MIN_ON_CYCLES-1 -> DEAD; estop=1 -> DEAD immediately regardless of dwell.
REQ-009 BRAKE: command != BRAKE_CMD, estop=0 and dwell count >= MIN_ON_CYCLES-1 -> DEAD; estop=1 -> stay.
REQ-010 DEAD: SHALL last exactly DEAD_CYCLES cycles; on the last cycle the next state is BRAKE if estop=1, else DRIVE/BRAKE/IDLE per the command sampled that cycle (using the newly evaluated owner).
REQ-011 A single dwell counter SHALL clear to 0 on every state entry, increment each cycle in DRIVE/BRAKE/DEAD, saturate at 255, and stay 0 in IDLE.
REQ-012 Latency: a command or estop change sampled at edge n SHALL appear on motor outputs after edge n (one cycle), subject to dwell/dead rules.
REQ-013 Ownership: man_gnt SHALL be re-evaluated only on cycles where state is IDLE or the last DEAD cycle (man_gnt_next = man_req), held otherwise; manual SHALL win simultaneous auto and manual demand.
REQ-014 Direct DRIVE<->BRAKE transitions SHALL NOT exist; every changeover passes through DEAD.

Reset
REQ-015 reset=1 at an edge SHALL force state IDLE, dwell 0, motor_fwd=0, motor_brk=0, man_gnt=0, state_o=00, from any state including mid-DRIVE/DEAD, with priority over estop.
REQ-016 No asynchronous reset path SHALL exist.

Structure
REQ-017 Shared package robot_ctrl_pkg SHALL hold the 2-bit state enum (IDLE/DRIVE/BRAKE/DEAD) and the command encoding constants (NONE/DRIVE_CMD/BRAKE_CMD).
REQ-018 The dwell counter SHALL be a sub-module motor_dwell_counter (clear, enable, saturating 8-bit count out); all other logic stays in robot_motor_sequencer.

Verification (defaults DEAD=4, MIN_ON=8; cycle k = output after edge k)
REQ-019 Reset held 2 cycles with all inputs 1 -> fwd=0, brk=0, man_gnt=0, state_o=00.
REQ-020 auto_drive=1 at edge 0, switched to auto_brake=1 at edge 2 -> fwd=1 cycles 0-7, both 0 cycles 8-11, brk=1 from cycle 12.
REQ-021 DRIVE entered at edge 0, estop=1 at edge 3 -> fwd=0 from cycle 3, DEAD cycles 3-6, brk=1 from cycle 7 held while estop=1.
REQ-022 From IDLE, auto_drive=auto_brake=1 -> brk=1 next cycle, fwd never 1.
REQ-023 Auto braking, man_req=1 with man_drive=1 -> man_gnt stays 0 until auto releases and DEAD ends; then man_gnt=1 and fwd=1 on the cycle after DEAD exit.
REQ-024 reset=1 at cycle 4 of DRIVE -> next cycle all outputs 0, state_o=00; subsequent auto_drive re-enters DRIVE with full MIN_ON dwell.
